microcode_sequencer: RTL and testbench

Microstep sequencer directly upstream of `instruction_decoder`. Holds the microstep counter, drives the 8-bit microcode ROM address `{opcode, step}` and resolves the one-cycle read latency of the registered microcode RAM. Gates the returned 16-bit control word onto the control bus for exactly one cycle per microstep. Handles end-of-instruction and halt.

---
 rtl/microcode_sequencer.sv | 90 +++++++++
 tb/tb_microcode_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microstep sequencer: presents {opcode, step} to the microcode ROM, strobes the returned
// control word for one cycle per microstep and handles halt. Option: MICROCODE_EARLY_END_EN.
module microcode_sequencer #(
  parameter int unsigned NUM_STEPS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  instruction,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] ctrl,
  output logic        ctrl_valid,
  output logic [3:0]  step,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);
  localparam logic [15:0] HLT_BIT = 16'h8000;

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic       strobe;
  logic       early_end;

`ifdef MICROCODE_EARLY_END_EN
  // An all-zero word past the fetch steps marks the end of the instruction.
  assign early_end = (rom_data == 16'h0000) && (step_q >= 4'd2);
`else
  assign early_end = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ISSUE;
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    strobe  = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (run) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // EXEC is always a single cycle; run is not consulted here.
        if ((rom_data & HLT_BIT) != 16'h0000) begin
          strobe  = 1'b1;
          state_d = ST_HALT;
        end else if (early_end) begin
          state_d = ST_ISSUE;
          step_d  = 4'd0;
        end else begin
          strobe  = 1'b1;
          state_d = ST_ISSUE;
          step_d  = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase
  end

  assign rom_addr   = {instruction[7:4], step_q};
  assign ctrl_valid = strobe;
  assign ctrl       = strobe ? rom_data : 16'h0000;
  assign step       = step_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: a registered microcode ROM model, a
// microstep-level reference model feeding an expected-strobe queue, and a negedge monitor.
module tb_microcode_sequencer;

  localparam int NUM_STEPS = 8;
`ifdef MICROCODE_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  instruction = 8'h00;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ctrl;
  logic        ctrl_valid;
  logic [3:0]  step;
  logic        halted;

  always #5 clk = ~clk;

  microcode_sequencer #(.NUM_STEPS(NUM_STEPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instruction(instruction),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .step       (step),
    .halted     (halted)
  );

  // Registered microcode ROM standing in for instruction_decoder.
  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [3:0]  step;
    logic [15:0] word;
  } strobe_t;

  strobe_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: microstep counter, halt flag, and whether a fetched word
  // is due on the control bus this cycle.
  int          m_step    = 0;
  bit          m_halted  = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_known   = 1'b0;
  logic [15:0] m_word    = 16'h0000;

  bit         exp_known  = 1'b0;
  bit         exp_valid  = 1'b0;
  logic [3:0] exp_step   = 4'd0;
  bit         exp_halted = 1'b0;
  bit         ir_follow  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle status plus scoreboard pops on each strobe.
  always @(negedge clk) begin
    strobe_t s;
    if (exp_known) begin
      check("ctrl_valid", {31'd0, ctrl_valid}, {31'd0, exp_valid});
      check("step", {28'd0, step}, {28'd0, exp_step});
      check("halted", {31'd0, halted}, {31'd0, exp_halted});
      check("rom_addr", {24'd0, rom_addr}, {24'd0, instruction[7:4], exp_step});
      if (ctrl_valid === 1'b1) begin
        check("strobe_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
          s = sb_q.pop_front();
          check("strobe_ctrl", {16'd0, ctrl}, {16'd0, s.word});
          check("strobe_step", {28'd0, step}, {28'd0, s.step});
        end
      end else begin
        check("ctrl_gated", {16'd0, ctrl}, 32'd0);
      end
    end
  end

  // One clock of stimulus: publish this cycle's expectation, advance the model, wait the edge.
  task automatic cyc(input bit rst_v, input bit run_v);
    bit      early_end;
    bit      load_ir;
    strobe_t s;
    reset      = rst_v;
    run        = run_v;
    exp_known  = m_known;
    exp_step   = 4'(m_step);
    exp_halted = m_halted;
    early_end  = EARLY && m_pending && (m_word == 16'h0000) && (m_step >= 2);
    exp_valid  = m_pending && !early_end;
    if (exp_valid && m_known) begin
      s.step = 4'(m_step);
      s.word = m_word;
      sb_q.push_back(s);
    end
    load_ir = ir_follow && exp_valid && m_word[10];
    if (rst_v) begin
      m_step    = 0;
      m_halted  = 1'b0;
      m_pending = 1'b0;
      m_known   = 1'b1;
    end else if (m_halted) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      m_pending = 1'b0;
      if (m_word[15])     m_halted = 1'b1;
      else if (early_end) m_step = 0;
      else                m_step = (m_step + 1) % NUM_STEPS;
    end else if (run_v) begin
      m_pending = 1'b1;
      m_word    = rom[{instruction[7:4], 4'(m_step)}];
    end
    @(posedge clk);
    #1;
    if (load_ir) instruction = 8'($urandom);
  endtask

  initial begin
    logic [15:0] w;
    for (int op = 0; op < 16; op++) begin
      for (int s = 0; s < 16; s++) begin
        w = 16'($urandom) & 16'h7fff;
        if ($urandom_range(3) == 0) w = 16'h0000;
        if (s == 0) w = 16'h4004;
        if (s == 1) w = 16'h1408;
        if (op == 0 && s >= 2) w = 16'h0000;
        if (op == 1 && s >= 2) w = (s == 2) ? 16'h4800 : (s == 3) ? 16'h1200 : 16'h0000;
        if (op == 15 && s >= 2) w = (s == 2) ? 16'h8000 : 16'h0000;
        if (op == 14 && s == 5) w = 16'h8000;
        rom[(op << 4) | s] = w;
      end
    end

    // Reset, then fetch and a full NOP instruction (wrap 7 -> 0).
    instruction = 8'h00;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);

    // LDA: 4800, 1200, then all-zero trailing steps.
    instruction = 8'h1E;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 18; i++) cyc(1'b0, 1'b1);

    // Run gating: stall five cycles in ISSUE at step 3.
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);

    // Halt at step 2, stay halted, then reset out.
    instruction = 8'hF0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 22; i++) cyc(1'b0, 1'($urandom));
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);

    // Reset asserted during the step-3 EXEC cycle.
    instruction = 8'h1E;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);

    // Randomized run: II strobes reload the instruction register.
    ir_follow = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) instruction = 8'($urandom);
      cyc($urandom_range(59) == 0, $urandom_range(3) != 0);
    end
    ir_follow = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
